// File: rtl/snn_enc_pkg.sv
`default_nettype none
// ============================================================================
// snn_enc_pkg : FSM encodings, LFSR geometry and helpers for the spike encoder
// Revision    : 1.0
// ============================================================================
package snn_enc_pkg;

    localparam int LFSR_W = 16;

    localparam int TAP_A = 15;
    localparam int TAP_B = 13;
    localparam int TAP_C = 12;
    localparam int TAP_D = 10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_REST = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
    endfunction

    function automatic logic [LFSR_W-1:0] bit_rev(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] r;
        r = '0;
        for (int i = 0; i < LFSR_W; i++) begin
            r[i] = s[LFSR_W-1-i];
        end
        return r;
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [LFSR_W-1:0] lfsr_seed(input int ch, input int step);
        logic [LFSR_W-1:0] s;
        s = LFSR_W'((ch + 1) * step);
        if (s == '0) begin
            s = LFSR_W'(1);
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16_ch.sv
`default_nettype none
// ============================================================================
// lfsr16_ch : per-channel 16-bit Fibonacci LFSR, advances only when enabled
// Revision  : 1.0
// ============================================================================
module lfsr16_ch
    import snn_enc_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'd1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_en,
    output logic [LFSR_W-1:0] o_state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (i_en) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_state = state_q;

endmodule
`default_nettype wire

// File: rtl/spike_encoder_par.sv
`default_nettype none
// ============================================================================
// spike_encoder_par : streams a stored frame from BRAM into N_CH parallel
//                     rate-coded spike trains, or a silent frame of equal timing
// Revision          : 1.0
// ============================================================================
module spike_encoder_par
    import snn_enc_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int PIX_W     = 8,
    parameter int ADDR_W    = 8,
    parameter int FRAME_LEN = 144,
    parameter int PIX_SHIFT = 2,
    parameter int SEED_STEP = 10000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_run,
    input  logic                    i_rest_run,
    input  logic [7:0]              i_steps,
    output logic [N_CH-1:0]         o_spike,
    output logic                    o_valid,
    output logic                    o_w_run,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [N_CH*PIX_W-1:0]   d,
    output logic [ADDR_W-1:0]       addr,
    output logic                    ce,
    output logic                    we,
    input  logic [N_CH*PIX_W-1:0]   q
);

    localparam logic [ADDR_W-1:0] C_LAST_WORD = ADDR_W'(FRAME_LEN - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] word_q,  word_d;
    logic [7:0]        step_q,  step_d;
    logic [7:0]        steps_q, steps_d;

    // Stage 1 tags travel alongside the BRAM read; stage 2 is the output register.
    logic v1_q,     v1_d;
    logic run1_q,   run1_d;
    logic first1_q, first1_d;
    logic last1_q,  last1_d;
    logic last2_q,  last2_d;

    logic [N_CH-1:0] o_spike_q, o_spike_d;
    logic            o_valid_q, o_valid_d;
    logic            o_w_run_q, o_w_run_d;
    logic            o_done_q,  o_done_d;

    logic            w_active;
    logic            w_last_word;
    logic            w_last_step;
    logic            w_lfsr_en;
    logic [N_CH-1:0] w_spike;

    assign w_active    = (state_q == ST_RUN) || (state_q == ST_REST);
    assign w_last_word = (word_q == C_LAST_WORD);
    assign w_last_step = (step_q == (steps_q - 8'd1));

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        step_d  = step_q;
        steps_d = steps_q;
        case (state_q)
            ST_IDLE: begin
                word_d = '0;
                step_d = '0;
                if (i_run || i_rest_run) begin
                    state_d = i_run ? ST_RUN : ST_REST;
                    steps_d = (i_steps == 8'd0) ? 8'd1 : i_steps;
                end
            end
            ST_RUN, ST_REST: begin
                if (w_last_word) begin
                    word_d = '0;
                    if (w_last_step) begin
                        step_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        step_d = step_q + 8'd1;
                    end
                end else begin
                    word_d = word_q + ADDR_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        v1_d      = w_active;
        run1_d    = (state_q == ST_RUN);
        first1_d  = w_active && (word_q == '0);
        last1_d   = w_active && w_last_word && w_last_step;
        last2_d   = last1_q;
        o_valid_d = v1_q;
        o_w_run_d = first1_q;
        o_spike_d = (v1_q && run1_q) ? w_spike : '0;
        o_done_d  = last2_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            step_q    <= '0;
            steps_q   <= 8'd1;
            v1_q      <= 1'b0;
            run1_q    <= 1'b0;
            first1_q  <= 1'b0;
            last1_q   <= 1'b0;
            last2_q   <= 1'b0;
            o_spike_q <= '0;
            o_valid_q <= 1'b0;
            o_w_run_q <= 1'b0;
            o_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            step_q    <= step_d;
            steps_q   <= steps_d;
            v1_q      <= v1_d;
            run1_q    <= run1_d;
            first1_q  <= first1_d;
            last1_q   <= last1_d;
            last2_q   <= last2_d;
            o_spike_q <= o_spike_d;
            o_valid_q <= o_valid_d;
            o_w_run_q <= o_w_run_d;
            o_done_q  <= o_done_d;
        end
    end

    // Random streams only move when a real pixel is being compared.
    assign w_lfsr_en = v1_q && run1_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        localparam logic [LFSR_W-1:0] C_SEED = lfsr_seed(k, SEED_STEP);

        logic [LFSR_W-1:0] w_state;
        logic [LFSR_W-1:0] w_pix;

        lfsr16_ch #(
            .SEED (C_SEED)
        ) u_lfsr (
            .clk     (clk),
            .reset_n (reset_n),
            .i_en    (w_lfsr_en),
            .o_state (w_state)
        );

        assign w_pix      = LFSR_W'(q[k*PIX_W +: PIX_W]) << PIX_SHIFT;
        assign w_spike[k] = (w_pix > bit_rev(w_state));
    end

    assign o_spike = o_spike_q;
    assign o_valid = o_valid_q;
    assign o_w_run = o_w_run_q;
    assign o_done  = o_done_q;
    assign o_busy  = (state_q != ST_IDLE);
    assign addr    = word_q;
    assign ce      = (state_q == ST_RUN);
    assign d       = '0;
    assign we      = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_spike_encoder_par.sv
`default_nettype none
// ============================================================================
// tb_spike_encoder_par : randomized self-checking bench against a frame-level model
// Revision             : 1.0
// ============================================================================
module tb_spike_encoder_par;

    localparam int N_CH      = 4;
    localparam int PIX_W     = 8;
    localparam int ADDR_W    = 8;
    localparam int FRAME_LEN = 144;
    localparam int PIX_SHIFT = 2;
    localparam int SEED_STEP = 10000;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  i_run = 1'b0;
    logic                  i_rest_run = 1'b0;
    logic [7:0]            i_steps = 8'd0;
    logic [N_CH-1:0]       o_spike;
    logic                  o_valid;
    logic                  o_w_run;
    logic                  o_busy;
    logic                  o_done;
    logic [N_CH*PIX_W-1:0] d;
    logic [ADDR_W-1:0]     addr;
    logic                  ce;
    logic                  we;
    logic [N_CH*PIX_W-1:0] q = '0;

    logic [N_CH*PIX_W-1:0] mem [FRAME_LEN];
    int                    m_lfsr [N_CH];
    int                    n_chk = 0;
    int                    n_err = 0;

    spike_encoder_par #(
        .N_CH      (N_CH),
        .PIX_W     (PIX_W),
        .ADDR_W    (ADDR_W),
        .FRAME_LEN (FRAME_LEN),
        .PIX_SHIFT (PIX_SHIFT),
        .SEED_STEP (SEED_STEP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_run      (i_run),
        .i_rest_run (i_rest_run),
        .i_steps    (i_steps),
        .o_spike    (o_spike),
        .o_valid    (o_valid),
        .o_w_run    (o_w_run),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .d          (d),
        .addr       (addr),
        .ce         (ce),
        .we         (we),
        .q          (q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ce) q <= mem[addr];
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rev16(input int s);
        int r = 0;
        for (int i = 0; i < 16; i++) if (((s >> i) & 1) != 0) r |= (1 << (15 - i));
        return r;
    endfunction

    function automatic int lfsr_step(input int s);
        int fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
        return ((s << 1) & 16'hFFFF) | fb;
    endfunction

    task automatic reseed_model();
        for (int k = 0; k < N_CH; k++) begin
            m_lfsr[k] = ((k + 1) * SEED_STEP) % 65536;
            if (m_lfsr[k] == 0) m_lfsr[k] = 1;
        end
    endtask

    task automatic fill_mem(input int mode);
        for (int w = 0; w < FRAME_LEN; w++) begin
            case (mode)
                0:       mem[w] = {N_CH{8'hFF}};
                1:       mem[w] = '0;
                default: mem[w] = $urandom;
            endcase
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lfsrs(input string tag);
        chk({tag, "_lfsr0"}, int'(dut.g_ch[0].u_lfsr.o_state), m_lfsr[0]);
        chk({tag, "_lfsr3"}, int'(dut.g_ch[3].u_lfsr.o_state), m_lfsr[3]);
    endtask

    task automatic run_frame(input string tag, input bit do_run, input bit do_rest,
                             input int steps_in, input int poke_at, input int abort_at);
        int              eff;
        int              total;
        logic [N_CH-1:0] exp_q[$];
        int              wrun_q[$];
        logic [N_CH-1:0] spk;
        int              pix;
        int              ce_cnt, ce_first, addr_err, vfirst, vcnt, gap;
        int              spk_err, done_cnt, done_cyc, busy_cnt, late_done;
        eff   = (steps_in == 0) ? 1 : steps_in;
        total = eff * FRAME_LEN;
        ce_cnt = 0; ce_first = -1; addr_err = 0; vfirst = -1; vcnt = 0; gap = 0;
        spk_err = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0; late_done = 0;

        for (int s = 0; s < eff; s++) begin
            for (int w = 0; w < FRAME_LEN; w++) begin
                spk = '0;
                if (do_run) begin
                    for (int k = 0; k < N_CH; k++) begin
                        pix = int'(mem[w][k*PIX_W +: PIX_W]);
                        if (((pix << PIX_SHIFT) & 16'hFFFF) > rev16(m_lfsr[k])) spk[k] = 1'b1;
                        m_lfsr[k] = lfsr_step(m_lfsr[k]);
                    end
                end
                exp_q.push_back(spk);
            end
        end

        i_run      = do_run;
        i_rest_run = do_rest;
        i_steps    = steps_in[7:0];
        step_clk();
        i_run      = 1'b0;
        i_rest_run = 1'b0;
        i_steps    = 8'($urandom);

        for (int cyc = 0; cyc < total + 12; cyc++) begin
            if (abort_at >= 0 && ce === 1'b1 && int'(addr) == abort_at) begin
                reset_n = 1'b0;
                #1;
                chk({tag, "_abort_busy"}, int'(o_busy), 0);
                chk({tag, "_abort_valid"}, int'(o_valid), 0);
                chk({tag, "_abort_ce"}, int'(ce), 0);
                chk({tag, "_abort_addr"}, int'(addr), 0);
                step_clk();
                step_clk();
                reset_n = 1'b1;
                for (int j = 0; j < 10; j++) begin
                    step_clk();
                    if (o_done === 1'b1 || o_valid === 1'b1) late_done++;
                end
                chk({tag, "_abort_quiet"}, late_done, 0);
                reseed_model();
                return;
            end
            if (ce === 1'b1) begin
                if (ce_first < 0) ce_first = cyc;
                if (int'(addr) != ce_cnt % FRAME_LEN) addr_err++;
                ce_cnt++;
            end
            if (o_busy === 1'b1) busy_cnt++;
            if (o_valid === 1'b1) begin
                if (vfirst < 0) vfirst = cyc;
                if (cyc != vfirst + vcnt) gap++;
                if (vcnt < exp_q.size() && o_spike !== exp_q[vcnt]) spk_err++;
                vcnt++;
            end else if (o_spike !== '0) begin
                spk_err++;
            end
            if (o_w_run === 1'b1) wrun_q.push_back((vfirst < 0) ? -1 : cyc - vfirst);
            if (o_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            i_run      = (cyc == poke_at);
            i_rest_run = (cyc == poke_at);
            step_clk();
        end
        i_run      = 1'b0;
        i_rest_run = 1'b0;

        chk({tag, "_ce_first"}, ce_first, do_run ? 0 : -1);
        chk({tag, "_ce_cnt"}, ce_cnt, do_run ? total : 0);
        chk({tag, "_addr_seq"}, addr_err, 0);
        chk({tag, "_busy_cnt"}, busy_cnt, total + 1);
        chk({tag, "_valid_first"}, vfirst, 2);
        chk({tag, "_valid_cnt"}, vcnt, total);
        chk({tag, "_valid_gap"}, gap, 0);
        chk({tag, "_spike_err"}, spk_err, 0);
        chk({tag, "_wrun_cnt"}, wrun_q.size(), eff);
        for (int i = 0; i < wrun_q.size() && i < eff; i++) begin
            chk({tag, "_wrun_off"}, wrun_q[i], i * FRAME_LEN);
        end
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_done_cyc"}, done_cyc, total + 2);
        chk_lfsrs(tag);
    endtask

    initial begin
        reseed_model();
        fill_mem(0);
        reset_n = 1'b0;
        repeat (3) step_clk();
        reset_n = 1'b1;
        #1;
        chk("rst_spike", int'(o_spike), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_wrun", int'(o_w_run), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_ce", int'(ce), 0);
        chk("rst_lfsr0", int'(dut.g_ch[0].u_lfsr.o_state), 10000);
        chk("rst_lfsr3", int'(dut.g_ch[3].u_lfsr.o_state), 40000);
        step_clk();

        fill_mem(0);
        run_frame("ff_s1", 1'b1, 1'b0, 1, -1, -1);

        fill_mem(1);
        run_frame("zero_s3", 1'b1, 1'b0, 3, -1, -1);

        fill_mem(2);
        run_frame("rest_s2", 1'b0, 1'b1, 2, -1, -1);

        run_frame("both_poke", 1'b1, 1'b1, 2, 5, -1);

        run_frame("steps0", 1'b1, 1'b0, 0, -1, -1);

        fill_mem(2);
        run_frame("abort", 1'b1, 1'b0, 2, -1, 70);
        fill_mem(2);
        run_frame("post_abort", 1'b1, 1'b0, 1, -1, -1);

        for (int r = 0; r < 4; r++) begin
            fill_mem(2);
            if ($urandom_range(0, 3) == 0)
                run_frame("rnd_rest", 1'b0, 1'b1, int'($urandom_range(0, 3)), -1, -1);
            else
                run_frame("rnd_run", 1'b1, 1'b0, int'($urandom_range(0, 3)), int'($urandom_range(3, 100)), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
